jesd204b_tx_link: RTL and testbench
===================================

JESD204B_TX_LINK -- requirements
Module: jesd204b_tx_link

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning lane datapath width; octets per clock N = DATA_WIDTH/8; one frame = one clock (F = N).
REQ-002 SHALL have parameter K, default 32, meaning frames (clocks) per multiframe; legal range 4..32.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sync_n  input  1  JESD204B SYNC~ from the receiver; low requests code-group sync.
REQ-006 SHALL have port in  input  DATA_WIDTH  scrambled user data; in[DATA_WIDTH-1:DATA_WIDTH-8] is octet 0, the first on the wire.
REQ-007 SHALL have port cfg  input  112  the 14 ILAS link-configuration octets; cfg[8i+7:8i] is config octet i; static outside CGS.
REQ-008 SHALL have port out  output  DATA_WIDTH  octets to the 8b/10b encoder, same octet order as in.
REQ-009 SHALL have port out_k  output  N  per-octet control flag; bit N-1 is octet 0; 1 = K character.
REQ-010 SHALL have port data_phase  output  1  high in DATA state; drives the scrambler en.
REQ-011 SHALL have port lmfc  output  1  one-clock pulse on the first frame of each multiframe.
REQ-012 SHALL have port sync_err  output  1  one-clock pulse when a sync_n low run shorter than 5 clocks ends.

Function
REQ-013 SHALL keep a multiframe counter 0..K-1, free-running from reset and wrapping K-1 -> 0; lmfc = (counter == 0).
REQ-014 SHALL register all outputs with one-clock latency from the in/state that produced them.
REQ-015 SHALL implement states CGS, ILAS and DATA.
REQ-016 CGS: every octet = 0xBC (K28.5), out_k all ones.
REQ-017 CGS -> ILAS only when sync_n is high and the counter wraps to 0; sync_n rising mid-multiframe waits for the next boundary.
REQ-018 ILAS SHALL last exactly 4 multiframes, tracked by a 2-bit multiframe index m, then go to DATA on the next boundary.
REQ-019 ILAS octet at multiframe position p (0..N*K-1): p=0 -> 0x1C /R/ (k=1); p=N*K-1 -> 0x7C /A/ (k=1); otherwise ramp octet p mod 256 (k=0).
REQ-020 ILAS m=1 overrides: p=1 -> 0x9C /Q/ (k=1); p=2..15 -> cfg octet p-2 (k=0).
REQ-021 DATA: out = registered in, out_k = 0, except as modified by REQ-027.
REQ-022 sync_n low for 5 consecutive clocks in ILAS or DATA SHALL enter CGS on the following clock, regardless of multiframe position.
REQ-023 sync_n low runs of 1..4 clocks in ILAS/DATA SHALL NOT change state; sync_err pulses on the clock sync_n returns high.
REQ-024 sync_n low while in CGS SHALL keep CGS and never assert sync_err.

Reset
REQ-025 While reset is low: state CGS, counter 0, m 0, low-run counter 0, out all 0xBC, out_k all ones, data_phase 0, lmfc 0, sync_err 0.
REQ-026 Reset assertion SHALL act immediately and asynchronously in any state, including mid-ILAS.

Configuration
REQ-027 With JESD204B_TX_CHAR_REPL_EN defined, in DATA the last octet of each frame equal to 0xFC SHALL be sent as K28.7 0xFC with k=1, and the last octet of the multiframe equal to 0x7C SHALL be sent as K28.3 0x7C with k=1 (multiframe rule first).
REQ-028 Without JESD204B_TX_CHAR_REPL_EN, DATA octets SHALL pass unmodified with out_k = 0.

Structure
REQ-029 A shared package SHALL hold the K-character constants (K28.0/3/4/5/7) and the state encoding.
REQ-030 One sub-module, jesd204b_ilas_gen, SHALL produce ILAS octets/flags from (m, counter, cfg); the top holds state, counters and the output register.

Verification
REQ-031 Reset low, sync_n low 100 clocks -> out 0xBCBCBCBCBCBCBCBC, out_k 0xFF, data_phase 0.
REQ-032 sync_n high at counter 10, K=32 -> CGS until counter wraps; first ILAS word 0x1C01020304050607 (out_k 0x80); last word of the multiframe ends 0x7C.
REQ-033 ILAS m=1, cfg octets 0x01..0x0E -> word0 0x1C9C010203040506 (out_k 0xC0), word1 0x0708090A0B0C0D0E (out_k 0x00); DATA starts exactly 4*K clocks after ILAS entry, data_phase 1.
REQ-034 DATA, sync_n low 3 clocks -> stays DATA, sync_err one pulse; low 5 clocks -> out 0xBC.. on clock 6.
REQ-035 With macro, in = 0x11223344556677FC mid-multiframe -> out_k 0x01; in last octet 0x7C at counter K-1 -> out_k 0x01; without macro both -> out_k 0x00.
REQ-036 Reset pulse mid-ILAS m=2 -> outputs at reset values at once; after release with sync_n high, full 4-multiframe ILAS restarts at next boundary.

Source files
------------

// File: rtl/jesd204b_tx_link_pkg.sv
// JESD204B transmit link layer: shared K characters and state encoding.
// Optional feature: JESD204B_TX_CHAR_REPL_EN (DATA-phase character replacement).
package jesd204b_tx_link_pkg;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_7 = 8'hFC;

    localparam int CNT_W = 5;

    localparam logic [1:0] ST_CGS  = 2'd0;
    localparam logic [1:0] ST_ILAS = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/jesd204b_ilas_gen.sv
// ILAS octet generator: maps (multiframe index, frame counter, cfg) to octets.
// Used by jesd204b_tx_link; independent of JESD204B_TX_CHAR_REPL_EN.
module jesd204b_ilas_gen
    import jesd204b_tx_link_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int K          = 32
) (
    input  logic [1:0]              i_m,
    input  logic [CNT_W-1:0]        i_cnt,
    input  logic [111:0]            i_cfg,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_k
);

    localparam int N    = DATA_WIDTH / 8;
    localparam int LAST = N * K - 1;

    logic [8:0] w_oct;

    // returns {k, octet} for multiframe position p
    function automatic logic [8:0] ilas_oct(
        input logic [1:0]   m,
        input int           p,
        input logic [111:0] cfg
    );
        logic [8:0] r;
        logic [3:0] q;
        q = 4'(p - 2);
        r = {1'b0, p[7:0]};
        if (p == 0)
            r = {1'b1, K28_0};
        else if (p == LAST)
            r = {1'b1, K28_3};
        else if (m == 2'd1 && p == 1)
            r = {1'b1, K28_4};
        else if (m == 2'd1 && p <= 15)
            r = {1'b0, cfg[{q, 3'b000} +: 8]};
        return r;
    endfunction

    always_comb begin
        o_data = '0;
        o_k    = '0;
        w_oct  = '0;
        for (int j = 0; j < N; j++) begin
            w_oct = ilas_oct(i_m, int'(i_cnt) * N + j, i_cfg);
            o_data[DATA_WIDTH-1-8*j -: 8] = w_oct[7:0];
            o_k[N-1-j] = w_oct[8];
        end
    end

endmodule

// File: rtl/jesd204b_tx_link.sv
// JESD204B transmit link layer: CGS / ILAS / DATA sequencing, LMFC, sync loss.
// Define JESD204B_TX_CHAR_REPL_EN to enable K28.7 / K28.3 character replacement.
module jesd204b_tx_link
    import jesd204b_tx_link_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int K          = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sync_n,
    input  logic [DATA_WIDTH-1:0]   in,
    input  logic [111:0]            cfg,
    output logic [DATA_WIDTH-1:0]   out,
    output logic [DATA_WIDTH/8-1:0] out_k,
    output logic                    data_phase,
    output logic                    lmfc,
    output logic                    sync_err
);

    localparam int N = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_m;
    logic [2:0]            r_lo;
    logic [DATA_WIDTH-1:0] r_out;
    logic [N-1:0]          r_k;
    logic                  r_dp;
    logic                  r_lmfc;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] w_ilas_d;
    logic [N-1:0]          w_ilas_k;
    logic [DATA_WIDTH-1:0] w_out;
    logic [N-1:0]          w_k;
    logic                  w_wrap;
    logic                  w_lost;

    jesd204b_ilas_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .K          (K)
    ) u_ilas (
        .i_m    (r_m),
        .i_cnt  (r_cnt),
        .i_cfg  (cfg),
        .o_data (w_ilas_d),
        .o_k    (w_ilas_k)
    );

    assign w_wrap = (r_cnt == CNT_LAST);
    // fifth consecutive low sample outside CGS
    assign w_lost = (r_state != ST_CGS) && !sync_n && (r_lo == 3'd4);

    always_comb begin
        w_out = {N{K28_5}};
        w_k   = '1;
        case (r_state)
            ST_ILAS: begin
                w_out = w_ilas_d;
                w_k   = w_ilas_k;
            end
            ST_DATA: begin
                w_out = in;
                w_k   = '0;
`ifdef JESD204B_TX_CHAR_REPL_EN
                if (w_wrap && in[7:0] == K28_3)
                    w_k[0] = 1'b1;
                else if (in[7:0] == K28_7)
                    w_k[0] = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CGS;
            r_cnt   <= '0;
            r_m     <= '0;
            r_lo    <= '0;
            r_out   <= {N{K28_5}};
            r_k     <= '1;
            r_dp    <= 1'b0;
            r_lmfc  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_lmfc <= (r_cnt == '0);
            r_err  <= (r_state != ST_CGS) && sync_n && (r_lo != 3'd0);
            r_out  <= w_out;
            r_k    <= w_k;
            r_dp   <= (r_state == ST_DATA);
            if (r_state == ST_CGS || sync_n || w_lost)
                r_lo <= '0;
            else
                r_lo <= r_lo + 1'b1;
            case (r_state)
                ST_CGS: begin
                    if (sync_n && w_wrap) begin
                        r_state <= ST_ILAS;
                        r_m     <= '0;
                    end
                end
                ST_ILAS: begin
                    if (w_lost) begin
                        r_state <= ST_CGS;
                    end else if (w_wrap) begin
                        if (r_m == 2'd3)
                            r_state <= ST_DATA;
                        r_m <= r_m + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_lost)
                        r_state <= ST_CGS;
                end
                default: r_state <= ST_CGS;
            endcase
        end
    end

    assign out        = r_out;
    assign out_k      = r_k;
    assign data_phase = r_dp;
    assign lmfc       = r_lmfc;
    assign sync_err   = r_err;

endmodule

// File: tb/tb_jesd204b_tx_link.sv
// Directed bench for jesd204b_tx_link (DATA_WIDTH=64, K=32).
// Expectations follow JESD204B_TX_CHAR_REPL_EN when the bench is built with it.
module tb_jesd204b_tx_link;

    localparam logic [63:0] CGS_W = 64'hBCBCBCBCBCBCBCBC;
`ifdef JESD204B_TX_CHAR_REPL_EN
    localparam logic [7:0] REPL_K = 8'h01;
`else
    localparam logic [7:0] REPL_K = 8'h00;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         sync_n;
    logic [63:0]  din;
    logic [111:0] cfg;
    logic [63:0]  dout;
    logic [7:0]   dk;
    logic         dp;
    logic         lmfc;
    logic         serr;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    jesd204b_tx_link #(
        .DATA_WIDTH (64),
        .K          (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sync_n     (sync_n),
        .in         (din),
        .cfg        (cfg),
        .out        (dout),
        .out_k      (dk),
        .data_phase (dp),
        .lmfc       (lmfc),
        .sync_err   (serr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic step_to(input int e);
        while (cyc < e) step();
    endtask

    initial begin
        reset  = 1'b0;
        sync_n = 1'b0;
        din    = '0;
        for (int i = 0; i < 14; i++) cfg[8*i +: 8] = 8'(i + 1);
        repeat (3) @(negedge clk);
        chk("rst_out", dout, CGS_W);
        chk("rst_k", dk, 8'hFF);
        chk("rst_dp", dp, 1'b0);
        chk("rst_lmfc", lmfc, 1'b0);
        chk("rst_err", serr, 1'b0);
        reset = 1'b1;
        cyc   = 0;

        step_to(100);
        chk("cgs_out", dout, CGS_W);
        chk("cgs_k", dk, 8'hFF);
        chk("cgs_dp", dp, 1'b0);
        chk("cgs_err", serr, 1'b0);

        step_to(106);
        sync_n = 1'b1;
        step_to(120);
        chk("cgs_wait", dout, CGS_W);
        step_to(128);
        chk("cgs_last", dout, CGS_W);
        step_to(129);
        chk("ilas0_w0", dout, 64'h1C01020304050607);
        chk("ilas0_k0", dk, 8'h80);
        chk("lmfc_on", lmfc, 1'b1);
        chk("ilas_dp", dp, 1'b0);
        step_to(130);
        chk("lmfc_off", lmfc, 1'b0);
        step_to(160);
        chk("ilas0_end", dout, 64'hF8F9FAFBFCFDFE7C);
        chk("ilas0_endk", dk, 8'h01);
        step_to(161);
        chk("ilas1_w0", dout, 64'h1C9C010203040506);
        chk("ilas1_k0", dk, 8'hC0);
        step_to(162);
        chk("ilas1_w1", dout, 64'h0708090A0B0C0D0E);
        chk("ilas1_k1", dk, 8'h00);
        step_to(193);
        chk("ilas2_w0", dout, 64'h1C01020304050607);

        din = 64'h0123456789ABCDEF;
        step_to(256);
        chk("ilas3_end", dout, 64'hF8F9FAFBFCFDFE7C);
        chk("pre_data_dp", dp, 1'b0);
        step_to(257);
        chk("data_dp", dp, 1'b1);
        chk("data_out", dout, 64'h0123456789ABCDEF);
        chk("data_k", dk, 8'h00);

        step_to(260);
        sync_n = 1'b0;
        step_to(263);
        chk("short_noerr", serr, 1'b0);
        sync_n = 1'b1;
        step_to(264);
        chk("short_err", serr, 1'b1);
        chk("short_dp", dp, 1'b1);
        step_to(265);
        chk("short_err_end", serr, 1'b0);

        step_to(269);
        din = 64'h11223344556677FC;
        step_to(270);
        chk("repl_fc_out", dout, 64'h11223344556677FC);
        chk("repl_fc_k", dk, REPL_K);
        din = 64'hA1A2A3A4A5A6A77C;
        step_to(287);
        chk("mid_7c_k", dk, 8'h00);
        step_to(288);
        chk("mf_7c_out", dout, 64'hA1A2A3A4A5A6A77C);
        chk("mf_7c_k", dk, REPL_K);

        din = 64'h5555AAAA5555AAAA;
        step_to(290);
        sync_n = 1'b0;
        step_to(295);
        chk("loss_c5_dp", dp, 1'b1);
        chk("loss_c5_out", dout, 64'h5555AAAA5555AAAA);
        step_to(296);
        chk("loss_c6_out", dout, CGS_W);
        chk("loss_c6_k", dk, 8'hFF);
        chk("loss_c6_dp", dp, 1'b0);
        chk("loss_noerr", serr, 1'b0);

        step_to(297);
        sync_n = 1'b1;
        step_to(321);
        chk("reilas_w0", dout, 64'h1C01020304050607);
        step_to(400);
        #2 reset = 1'b0;
        #1;
        chk("arst_out", dout, CGS_W);
        chk("arst_k", dk, 8'hFF);
        chk("arst_dp", dp, 1'b0);
        chk("arst_lmfc", lmfc, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;

        step_to(32);
        chk("rel_cgs", dout, CGS_W);
        step_to(33);
        chk("rel_ilas0", dout, 64'h1C01020304050607);
        chk("rel_ilas0_k", dk, 8'h80);
        step_to(65);
        chk("rel_ilas1", dout, 64'h1C9C010203040506);
        step_to(160);
        chk("rel_pre_dp", dp, 1'b0);
        step_to(161);
        chk("rel_dp", dp, 1'b1);
        chk("rel_data", dout, 64'h5555AAAA5555AAAA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
